// File: rtl/lbist_sequencer.sv
// LBIST control FSM: sequences TPG, MISR and the PI mux select, then compares the final signature.
// Optional abort support is compiled in with `define LBIST_ABORT_EN.
module lbist_sequencer #(
  parameter int unsigned          N_PATTERNS    = 1024,
  parameter int unsigned          SETTLE_CYCLES = 2,
  parameter int unsigned          SIG_WIDTH     = 32,
  parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG    = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 normal_test,
  input  logic [SIG_WIDTH-1:0] misr_sig,
  output logic                 tpg_clr,
  output logic                 tpg_en,
  output logic                 misr_clr,
  output logic                 misr_en,
  output logic                 test_mode,
  output logic                 testing,
  output logic                 test_over,
  output logic                 go_nogo
`ifdef LBIST_ABORT_EN
  ,
  input  logic                 abort,
  output logic                 aborted
`endif
);

  localparam int unsigned PCW = $clog2(N_PATTERNS + 1);
  localparam int unsigned SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [PCW-1:0] PAT_LAST = PCW'(N_PATTERNS - 1);
  localparam logic [SCW-1:0] SET_LAST = SCW'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    SETTLE  = 3'd2,
    RUN     = 3'd3,
    COMPARE = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic [SCW-1:0] set_cnt_q, set_cnt_d;
  logic [PCW-1:0] pat_cnt_q, pat_cnt_d;
  logic           normal_test_q;
  logic           armed_q;
  logic           start;
  logic           active;
  logic           abort_hit;
  logic           start_hit;

  // armed_q blocks the first cycle after reset so a level already high is not seen as an edge
  assign start  = normal_test & ~normal_test_q & armed_q;
  assign active = (state_q == INIT) || (state_q == SETTLE) ||
                  (state_q == RUN)  || (state_q == COMPARE);

`ifdef LBIST_ABORT_EN
  assign abort_hit = abort & active;
`else
  assign abort_hit = 1'b0;
`endif

  assign start_hit = start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d   = state_q;
    set_cnt_d = set_cnt_q;
    pat_cnt_d = pat_cnt_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = INIT;
      INIT: begin
        set_cnt_d = '0;
        pat_cnt_d = '0;
        state_d   = (SETTLE_CYCLES == 0) ? RUN : SETTLE;
      end
      SETTLE: begin
        if (set_cnt_q == SET_LAST) begin
          set_cnt_d = '0;
          state_d   = RUN;
        end else begin
          set_cnt_d = set_cnt_q + SCW'(1);
        end
      end
      RUN: begin
        if (pat_cnt_q == PAT_LAST) begin
          pat_cnt_d = '0;
          state_d   = COMPARE;
        end else begin
          pat_cnt_d = pat_cnt_q + PCW'(1);
        end
      end
      COMPARE: state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (abort_hit) begin
      state_d   = DONE;
      set_cnt_d = '0;
      pat_cnt_d = '0;
    end
  end

  // Outputs are registered from the next state so they track the state register exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      set_cnt_q     <= '0;
      pat_cnt_q     <= '0;
      normal_test_q <= 1'b0;
      armed_q       <= 1'b0;
      tpg_clr       <= 1'b0;
      tpg_en        <= 1'b0;
      misr_clr      <= 1'b0;
      misr_en       <= 1'b0;
      test_mode     <= 1'b0;
      testing       <= 1'b0;
      test_over     <= 1'b0;
      go_nogo       <= 1'b0;
`ifdef LBIST_ABORT_EN
      aborted       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      set_cnt_q     <= set_cnt_d;
      pat_cnt_q     <= pat_cnt_d;
      normal_test_q <= normal_test;
      armed_q       <= 1'b1;
      tpg_clr       <= (state_d == INIT);
      misr_clr      <= (state_d == INIT);
      tpg_en        <= (state_d == SETTLE) || (state_d == RUN);
      misr_en       <= (state_d == RUN);
      test_mode     <= (state_d == INIT) || (state_d == SETTLE) ||
                       (state_d == RUN)  || (state_d == COMPARE);
      testing       <= (state_d == INIT) || (state_d == SETTLE) ||
                       (state_d == RUN)  || (state_d == COMPARE);
      if (start_hit) begin
        test_over <= 1'b0;
        go_nogo   <= 1'b0;
`ifdef LBIST_ABORT_EN
        aborted   <= 1'b0;
`endif
      end
      if (abort_hit) begin
        test_over <= 1'b1;
        go_nogo   <= 1'b0;
`ifdef LBIST_ABORT_EN
        aborted   <= 1'b1;
`endif
      end else if (state_q == COMPARE) begin
        test_over <= 1'b1;
        go_nogo   <= (misr_sig == GOLDEN_SIG);
      end
    end
  end

endmodule

// File: tb/tb_lbist_sequencer.sv
// Directed bench for lbist_sequencer (N_PATTERNS=8, SETTLE_CYCLES=2, GOLDEN_SIG=DEADBEEF).
module tb_lbist_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        normal_test;
  logic [31:0] misr_sig;
  logic        tpg_clr, tpg_en, misr_clr, misr_en, test_mode, testing, test_over, go_nogo;
`ifdef LBIST_ABORT_EN
  logic        abort;
  logic        aborted;
`endif

  int n_chk = 0;
  int n_err = 0;
  int c_tclr, c_mclr, c_ten, c_men, c_tst, c_mode;

  always #5 clk = ~clk;

  lbist_sequencer #(
    .N_PATTERNS   (8),
    .SETTLE_CYCLES(2),
    .SIG_WIDTH    (32),
    .GOLDEN_SIG   (32'hDEADBEEF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .normal_test(normal_test),
    .misr_sig   (misr_sig),
    .tpg_clr    (tpg_clr),
    .tpg_en     (tpg_en),
    .misr_clr   (misr_clr),
    .misr_en    (misr_en),
    .test_mode  (test_mode),
    .testing    (testing),
    .test_over  (test_over),
    .go_nogo    (go_nogo)
`ifdef LBIST_ABORT_EN
    ,
    .abort      (abort),
    .aborted    (aborted)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_cnt();
    c_tclr = 0; c_mclr = 0; c_ten = 0; c_men = 0; c_tst = 0; c_mode = 0;
  endtask

  // Advance n clocks, sampling 1 time unit after each rising edge
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      c_tclr += int'(tpg_clr);
      c_mclr += int'(misr_clr);
      c_ten  += int'(tpg_en);
      c_men  += int'(misr_en);
      c_tst  += int'(testing);
      c_mode += int'(test_mode);
    end
  endtask

  function automatic logic [7:0] outs();
    return {tpg_clr, tpg_en, misr_clr, misr_en, test_mode, testing, test_over, go_nogo};
  endfunction

  initial begin
    rst_n = 1'b0; normal_test = 1'b0; misr_sig = '0;
`ifdef LBIST_ABORT_EN
    abort = 1'b0;
`endif
    clr_cnt();
    #12;
    check("reset_outs", 32'(outs()), 32'h0);
`ifdef LBIST_ABORT_EN
    check("reset_aborted", 32'(aborted), 32'h0);
`endif
    @(posedge clk); #1; rst_n = 1'b1;

    // 1: idle for 20 cycles
    clr_cnt();
    cycles(20);
    check("idle_activity", 32'(c_tclr + c_mclr + c_ten + c_men + c_tst + c_mode), 32'd0);
    check("idle_outs", 32'(outs()), 32'h0);

    // 2: single pulse, matching signature
    misr_sig = 32'hDEADBEEF;
    normal_test = 1'b1;
    clr_cnt();
    cycles(1);
    normal_test = 1'b0;
    check("init_latency", 32'({tpg_clr, misr_clr, test_mode, testing, tpg_en, misr_en}), 32'b111100);
    check("init_test_over", 32'(test_over), 32'h0);
    cycles(11);
    check("cmp_state", 32'({test_mode, testing, tpg_en, misr_en, test_over}), 32'b11000);
    cycles(3);
    check("pass_tpg_clr", 32'(c_tclr), 32'd1);
    check("pass_misr_clr", 32'(c_mclr), 32'd1);
    check("pass_tpg_en", 32'(c_ten), 32'd10);
    check("pass_misr_en", 32'(c_men), 32'd8);
    check("pass_testing", 32'(c_tst), 32'd12);
    check("pass_result", 32'({test_over, go_nogo, testing, test_mode}), 32'b1100);

    // 3: mismatching signature, result held
    misr_sig = 32'hDEADBEEE;
    normal_test = 1'b1;
    clr_cnt();
    cycles(1);
    normal_test = 1'b0;
    check("rerun_clears_over", 32'({test_over, go_nogo}), 32'b00);
    cycles(14);
    check("fail_testing", 32'(c_tst), 32'd12);
    check("fail_result", 32'({test_over, go_nogo}), 32'b10);
    cycles(6);
    check("fail_held", 32'({test_over, go_nogo}), 32'b10);

    // 4: level held high gives one run, then re-raise in DONE
    misr_sig = 32'hDEADBEEF;
    normal_test = 1'b1;
    clr_cnt();
    cycles(30);
    check("held_one_run", 32'(c_tst), 32'd12);
    check("held_result", 32'({test_over, go_nogo}), 32'b11);
    normal_test = 1'b0;
    cycles(1);
    normal_test = 1'b1;
    clr_cnt();
    cycles(1);
    check("reraise_init", 32'({tpg_clr, testing, test_over}), 32'b110);
    cycles(13);
    check("reraise_done", 32'({test_over, go_nogo, testing}), 32'b110);
    check("reraise_testing", 32'(c_tst), 32'd12);

    // 5: reset in RUN cycle 4, level still high after release
    normal_test = 1'b0;
    cycles(1);
    normal_test = 1'b1;
    cycles(3);
    cycles(4);
    check("run4_active", 32'({misr_en, tpg_en, testing}), 32'b111);
    rst_n = 1'b0;
    #1;
    check("async_reset_outs", 32'(outs()), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clr_cnt();
    cycles(10);
    check("post_reset_no_start", 32'(c_tst + c_ten + c_tclr), 32'd0);
    check("post_reset_outs", 32'(outs()), 32'h0);

`ifdef LBIST_ABORT_EN
    // 6: abort after RUN cycle 3
    normal_test = 1'b0;
    cycles(1);
    normal_test = 1'b1;
    clr_cnt();
    cycles(6);
    abort = 1'b1;
    cycles(1);
    abort = 1'b0;
    check("abort_result", 32'({test_over, go_nogo, aborted, testing}), 32'b1010);
    check("abort_misr_en", 32'(c_men), 32'd3);
    cycles(3);
    check("abort_held", 32'({test_over, aborted, c_men == 3}), 32'b111);
    normal_test = 1'b0;
    cycles(1);
    normal_test = 1'b1;
    cycles(1);
    check("abort_cleared_init", 32'({aborted, test_over, tpg_clr}), 32'b001);
    cycles(13);
    check("after_abort_pass", 32'({test_over, go_nogo, aborted}), 32'b110);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
